icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter LINE_NUM, default 16, number of direct-mapped lines (power of two, 2..64).
REQ-002 Parameter LINE_BYTES, default 64, bytes per line; equals the memory controller fetch burst length.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rdy  input  1  global ready; low freezes all state.
REQ-006 rollback  input  1  pipeline flush; cancels the pending fetch response.
REQ-007 fe_en  input  1  fetch request valid.
REQ-008 fe_pc  input  32  fetch address, 4-byte aligned.
REQ-009 fe_hit  output  1  fe_inst valid for current fe_pc.
REQ-010 fe_inst  output  32  instruction word at fe_pc.
REQ-011 mem_if_en  output  1  line-fill request to memory controller.
REQ-012 mem_if_pc  output  32  line-aligned fill address.
REQ-013 mem_if_data  input  8*LINE_BYTES  filled line, byte i at bits [8i+7:8i].
REQ-014 mem_if_done  input  1  one-cycle pulse: mem_if_data valid.

Function
REQ-015 Address split: offset = pc[5:0], index = pc[6+log2(LINE_NUM)-1:6], tag = remaining upper bits.
REQ-016 fe_hit = fe_en && valid[index] && tag_arr[index]==tag, combinational, same cycle as request; fe_inst = word pc[5:2] of data[index] (little-endian).
REQ-017 FSM states IDLE, WAIT.
REQ-018 IDLE: fe_en && !fe_hit && !rollback -> WAIT; registers mem_if_en<=1, mem_if_pc<={fe_pc[31:6],6'b0}.
REQ-019 WAIT: mem_if_en and mem_if_pc held stable until mem_if_done; fe_hit forced 0 during WAIT.
REQ-020 WAIT with mem_if_done: write line, tag, valid[index]<=1; mem_if_en<=0; -> IDLE; hit served no earlier than next cycle.
REQ-021 rollback in WAIT does not abort the fill (controller fetches do not abort); line is still installed, only the response is discarded; fe_pc may change freely.
REQ-022 rollback in IDLE: no new fill started that cycle; fe_hit forced 0.
REQ-023 Miss latency: request at cycle t, mem_if_en high at t+1, fe_hit at done+1.
REQ-024 Re-fill of an already valid index overwrites it (no replacement choice).
REQ-025 mem_if_done while IDLE is ignored.
REQ-026 rdy low: no state change, outputs hold; fe_hit still combinational from frozen arrays.

Reset
REQ-027 rst: FSM IDLE, all valid bits 0, mem_if_en 0, mem_if_pc 0, fe_hit 0; data/tag arrays not cleared.
REQ-028 rst mid-WAIT drops the fill; a later stray mem_if_done is ignored per REQ-025.
REQ-029 rst takes priority over rdy.

Configuration
REQ-030 Macro ICACHE_STATS_EN: when defined, outputs hit_cnt[31:0] and miss_cnt[31:0] exist, reset to 0, increment once per cycle on fe_hit and once per IDLE->WAIT transition, wrap at 2^32.
REQ-031 Without ICACHE_STATS_EN the counters and ports are absent; all other behaviour identical.

Structure
REQ-032 Shared define file holds ICACHE_LINE_BYTES (= MEM_CTRL_IF_DATA_LEN) and state encodings IDLE/WAIT.
REQ-033 One sub-module, icache_data_array: LINE_NUM x 8*LINE_BYTES storage, one write port, one combinational read port.

Verification
REQ-034 Reset, fe_en=1 pc=0x0000_0100 -> fe_hit=0, next cycle mem_if_en=1 mem_if_pc=0x0000_0100.
REQ-035 Return line with byte k = k, done pulse -> next cycle fe_hit=1, fe_inst=0x03020100; pc=0x0000_0104 -> 0x07060504 with no fill.
REQ-036 Fill 0x0000_0100, then pc=0x0000_0500 (same index, different tag) -> miss, refill; pc=0x0000_0100 again -> miss.
REQ-037 rollback during WAIT, fe_pc changed to 0x0000_0200 -> fill of 0x0000_0100 completes, no hit reported for 0x0200 until its own fill.
REQ-038 rdy low 5 cycles across mem_if_done-less WAIT -> mem_if_en/mem_if_pc unchanged; rst in WAIT -> mem_if_en=0 next cycle, valid cleared.
REQ-039 With ICACHE_STATS_EN: 1 miss + 3 hit cycles -> miss_cnt=1, hit_cnt=3.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared line geometry, FSM encoding and address helper for the icache
package icache_pkg;

  localparam int MEM_CTRL_IF_DATA_LEN = 64;
  localparam int ICACHE_LINE_BYTES    = MEM_CTRL_IF_DATA_LEN;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } icache_state_e;

  function automatic logic [31:0] line_base(input logic [31:0] pc, input int off_w);
    return (pc >> off_w) << off_w;
  endfunction

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-fill-side bundles for the icache
interface icache_fe_if;
  logic        fe_en;
  logic [31:0] fe_pc;
  logic        rollback;
  logic        fe_hit;
  logic [31:0] fe_inst;

  modport master (output fe_en, fe_pc, rollback, input fe_hit, fe_inst);
  modport slave  (input fe_en, fe_pc, rollback, output fe_hit, fe_inst);
endinterface

interface icache_mem_if import icache_pkg::*; #(
  parameter int LINE_BYTES = ICACHE_LINE_BYTES
);
  logic                    mem_if_en;
  logic [31:0]             mem_if_pc;
  logic [8*LINE_BYTES-1:0] mem_if_data;
  logic                    mem_if_done;

  modport master (output mem_if_en, mem_if_pc, input mem_if_data, mem_if_done);
  modport slave  (input mem_if_en, mem_if_pc, output mem_if_data, mem_if_done);
endinterface

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - line storage, one write port and one combinational read port
module icache_data_array import icache_pkg::*; #(
  parameter  int LINE_NUM   = 16,
  parameter  int LINE_BYTES = ICACHE_LINE_BYTES,
  localparam int IDX_W      = $clog2(LINE_NUM)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [8*LINE_BYTES-1:0] wdata,
  input  logic [IDX_W-1:0]        raddr,
  output logic [8*LINE_BYTES-1:0] rdata
);

  logic [8*LINE_BYTES-1:0] lines [LINE_NUM];

  always_ff @(posedge clk) begin
    if (we) begin
      lines[waddr] <= wdata;
    end
  end

  assign rdata = lines[raddr];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with single outstanding line fill
// Optional hit/miss counters enabled by defining ICACHE_STATS_EN.
module icache import icache_pkg::*; #(
  parameter int LINE_NUM   = 16,
  parameter int LINE_BYTES = ICACHE_LINE_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  icache_fe_if.slave   fe,
  icache_mem_if.master mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(LINE_NUM);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WSEL_W = $clog2(LINE_BYTES / 4);

  icache_state_e           state;
  logic                    fill_en;
  logic [31:0]             fill_pc;
  logic [LINE_NUM-1:0]     valid;
  logic [TAG_W-1:0]        tag_arr [LINE_NUM];
  logic [8*LINE_BYTES-1:0] rd_line;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] word_sel;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              lookup_hit;
  logic              fe_hit;
  logic              fill_fire;

  assign idx      = fe.fe_pc[OFF_W +: IDX_W];
  assign tag      = fe.fe_pc[31 -: TAG_W];
  assign word_sel = fe.fe_pc[2 +: WSEL_W];
  // Fills are indexed from the latched request, since fe_pc may wander after a rollback.
  assign fill_idx = fill_pc[OFF_W +: IDX_W];
  assign fill_tag = fill_pc[31 -: TAG_W];

  assign lookup_hit = valid[idx] && (tag_arr[idx] == tag);
  assign fe_hit     = fe.fe_en && lookup_hit && (state == IDLE) && !fe.rollback && !rst;
  assign fill_fire  = (state == WAIT) && mem.mem_if_done && rdy && !rst;

  assign fe.fe_hit     = fe_hit;
  assign fe.fe_inst    = rd_line[{word_sel, 5'd0} +: 32];
  assign mem.mem_if_en = fill_en;
  assign mem.mem_if_pc = fill_pc;

  icache_data_array #(
    .LINE_NUM   (LINE_NUM),
    .LINE_BYTES (LINE_BYTES)
  ) u_data (
    .clk   (clk),
    .we    (fill_fire),
    .waddr (fill_idx),
    .wdata (mem.mem_if_data),
    .raddr (idx),
    .rdata (rd_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= '0;
      fill_en <= 1'b0;
      fill_pc <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (fe.fe_en && !fe_hit && !fe.rollback) begin
            state   <= WAIT;
            fill_en <= 1'b1;
            fill_pc <= line_base(fe.fe_pc, OFF_W);
          end
        end
        WAIT: begin
          if (mem.mem_if_done) begin
            valid[fill_idx]   <= 1'b1;
            tag_arr[fill_idx] <= fill_tag;
            fill_en           <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy) begin
      if (fe_hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if ((state == IDLE) && fe.fe_en && !fe_hit && !fe.rollback) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache: directed scenarios then randomized fetch traffic
module tb_icache;
  import icache_pkg::*;

  localparam int LN = 16;
  localparam int LB = ICACHE_LINE_BYTES;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  icache_fe_if fe ();
  icache_mem_if #(.LINE_BYTES(LB)) mem ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache #(
    .LINE_NUM   (LN),
    .LINE_BYTES (LB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .fe  (fe),
    .mem (mem)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  ev_t hit_q[$];
  ev_t fill_q[$];
  int  drop_q[$];

  // Reference model: which line address lives at each index, and the outstanding fill.
  bit          mv[LN];
  logic [31:0] mline[LN];
  bit          m_busy = 0;
  logic [31:0] m_fill = '0;
  int          m_hits = 0;
  int          m_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] ln, input int k);
    logic [31:0] l;
    l = ln >> 6;
    return (8'(k) + 8'((l - 32'd4) * 32'd37)) ^ 8'(l >> 8) ^ 8'(l >> 16) ^ 8'(l >> 24);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] ln, input int w);
    return {mem_byte(ln, 4*w+3), mem_byte(ln, 4*w+2), mem_byte(ln, 4*w+1), mem_byte(ln, 4*w)};
  endfunction

  function automatic logic [8*LB-1:0] mem_line(input logic [31:0] ln);
    logic [8*LB-1:0] d;
    for (int k = 0; k < LB; k++) d[8*k +: 8] = mem_byte(ln, k);
    return d;
  endfunction

  function automatic logic [8*LB-1:0] rand_line();
    logic [8*LB-1:0] d;
    for (int k = 0; k < LB/4; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  // One clock of stimulus; expectations are derived from the model state before the edge.
  task automatic step(input bit en, input logic [31:0] pc, input bit rb, input bit rd,
                      input bit rs, input bit dn);
    logic [31:0] ln;
    int          ix;
    bit          res;
    ev_t         e;
    fe.fe_en        = en;
    fe.fe_pc        = pc;
    fe.rollback     = rb;
    rdy             = rd;
    rst             = rs;
    mem.mem_if_done = dn;
    mem.mem_if_data = dn ? mem_line(m_busy ? m_fill : ($urandom & 32'hFFFF_FFC0)) : rand_line();
    ln  = pc & 32'hFFFF_FFC0;
    ix  = int'((pc >> 6) % LN);
    res = mv[ix] && (mline[ix] == ln);
    if (rs) begin
      if (m_busy) drop_q.push_back(cyc + 1);
      m_busy = 0;
      for (int i = 0; i < LN; i++) mv[i] = 0;
      m_hits = 0;
      m_miss = 0;
    end else begin
      if (!m_busy && en && !rb && res) begin
        e.cyc = cyc;
        e.val = mem_word(ln, int'(pc[5:2]));
        hit_q.push_back(e);
        if (rd) m_hits++;
      end
      if (rd) begin
        if (!m_busy && en && !rb && !res) begin
          m_busy = 1;
          m_fill = ln;
          e.cyc  = cyc + 1;
          e.val  = ln;
          fill_q.push_back(e);
          m_miss++;
        end else if (m_busy && dn) begin
          mv[(m_fill >> 6) % LN]    = 1;
          mline[(m_fill >> 6) % LN] = m_fill;
          m_busy = 0;
          drop_q.push_back(cyc + 1);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_wait(input logic [31:0] pc, input int n);
    repeat (n) step(1, pc, 0, 1, 0, 0);
    step(1, pc, 0, 1, 0, 1);
  endtask

  // Monitor: consumes expectations whenever the DUT presents a hit or moves its fill request.
  logic        prev_en  = 1'b0;
  logic [31:0] cur_fill = '0;
  always @(negedge clk) begin
    ev_t e;
    if (fe.fe_hit === 1'b1) begin
      if (hit_q.size() == 0) begin
        check("unexpected_hit_pc", fe.fe_pc, 32'hxxxx_xxxx);
      end else begin
        e = hit_q.pop_front();
        check("hit_cycle", 32'(cyc), 32'(e.cyc));
        check("fe_inst", fe.fe_inst, e.val);
      end
    end
    if (mem.mem_if_en === 1'b1 && prev_en !== 1'b1) begin
      if (fill_q.size() == 0) begin
        check("unexpected_fill_pc", mem.mem_if_pc, 32'hxxxx_xxxx);
      end else begin
        e = fill_q.pop_front();
        cur_fill = e.val;
        check("fill_cycle", 32'(cyc), 32'(e.cyc));
        check("fill_pc", mem.mem_if_pc, e.val);
      end
    end else if (mem.mem_if_en === 1'b1) begin
      check("fill_pc_hold", mem.mem_if_pc, cur_fill);
    end else if (mem.mem_if_en === 1'b0 && prev_en === 1'b1) begin
      if (drop_q.size() == 0) begin
        check("unexpected_fill_drop", 32'(cyc), 32'hxxxx_xxxx);
      end else begin
        check("fill_drop_cycle", 32'(cyc), 32'(drop_q.pop_front()));
      end
    end
    prev_en = mem.mem_if_en;
  end

  initial begin
    logic [31:0] pc;
    bit          en, rb, rd, rs, dn;
    fe.fe_en        = 1'b0;
    fe.fe_pc        = '0;
    fe.rollback     = 1'b0;
    mem.mem_if_done = 1'b0;
    mem.mem_if_data = '0;
    for (int i = 0; i < LN; i++) begin
      mv[i]    = 0;
      mline[i] = '0;
    end
    @(posedge clk);
    #1;
    step(0, 32'h0, 0, 1, 1, 0);
    step(1, 32'h0000_0100, 0, 0, 1, 0);
    check("reset_fe_hit", {31'd0, fe.fe_hit}, 32'd0);
    check("reset_mem_if_en", {31'd0, mem.mem_if_en}, 32'd0);
    check("reset_mem_if_pc", mem.mem_if_pc, 32'd0);

    // Cold miss, fill, then hits in the same line without a new fill.
    step(1, 32'h0000_0100, 0, 1, 0, 0);
    fill_wait(32'h0000_0100, 3);
    step(1, 32'h0000_0100, 0, 1, 0, 0);
    step(1, 32'h0000_0104, 0, 1, 0, 0);
    step(1, 32'h0000_013C, 0, 1, 0, 0);

    // Conflict on the same index evicts; rollback mid-fill still installs the old line.
    step(1, 32'h0000_0500, 0, 1, 0, 0);
    fill_wait(32'h0000_0500, 2);
    step(1, 32'h0000_0100, 0, 1, 0, 0);
    step(1, 32'h0000_0100, 0, 1, 0, 0);
    step(1, 32'h0000_0200, 1, 1, 0, 0);
    step(1, 32'h0000_0200, 0, 1, 0, 0);
    step(1, 32'h0000_0200, 0, 1, 0, 1);
    fill_wait(32'h0000_0200, 2);
    step(1, 32'h0000_0200, 0, 1, 0, 0);
    step(1, 32'h0000_0108, 0, 1, 0, 0);
    step(1, 32'h0000_0508, 0, 1, 0, 0);
    fill_wait(32'h0000_0508, 1);

    // Freeze during a fill, reset mid-fill, then a stray done that must be ignored.
    step(1, 32'h0000_0300, 0, 1, 0, 0);
    repeat (5) step(1, 32'h0000_0300, 0, 0, 0, 0);
    step(0, 32'h0000_0300, 0, 0, 1, 0);
    step(0, 32'h0000_0300, 0, 1, 0, 1);
    step(1, 32'h0000_0200, 0, 1, 0, 0);
    fill_wait(32'h0000_0200, 1);

    // Exactly one miss and three hit cycles since the last reset.
    step(1, 32'h0000_0204, 0, 1, 0, 0);
    step(1, 32'h0000_0208, 0, 1, 0, 0);
    step(1, 32'h0000_020C, 0, 1, 0, 0);
`ifdef ICACHE_STATS_EN
    check("stats_miss_directed", miss_cnt, 32'd1);
    check("stats_hit_directed", hit_cnt, 32'd3);
`endif

    pc = 32'h0000_0100;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 35) begin
        case ($urandom_range(0, 3))
          0:       pc = 32'h8000_0000;
          1:       pc = 32'h0004_0000;
          default: pc = 32'h0000_0000;
        endcase
        pc = pc | (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, LN-1)) << 6);
      end
      pc[5:2] = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 199) == 0);
      en = !rs && ($urandom_range(0, 99) < 85);
      rb = ($urandom_range(0, 99) < 8);
      rd = ($urandom_range(0, 99) < 85);
      dn = m_busy ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 3);
      step(en, pc, rb, rd, rs, dn);
    end

    step(0, 32'h0, 0, 1, 0, 0);
    step(0, 32'h0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    check("pending_hits", 32'(hit_q.size()), 32'd0);
    check("pending_fills", 32'(fill_q.size()), 32'd0);
    check("pending_drops", 32'(drop_q.size()), 32'd0);
`ifdef ICACHE_STATS_EN
    check("stats_hit_cnt", hit_cnt, 32'(m_hits));
    check("stats_miss_cnt", miss_cnt, 32'(m_miss));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
